// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key decode, joystick merge, autofire,
// coin pulse stretching and DIP-switch capture from the download stream.
module arcade_input_mapper #(
    parameter int          NUM_PLAYERS   = 2,
    parameter int          NUM_DIP_BYTES = 1,
    parameter int          MERGE_PLAYERS = 1,
    parameter logic [23:0] COIN_CYCLES   = 24'd240000,
    parameter logic [19:0] AUTOFIRE_DIV  = 20'd400000
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [63:0]                joy,
    input  logic [NUM_PLAYERS-1:0]     autofire_en,
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    output logic [8*NUM_PLAYERS-1:0]   players,
    output logic [NUM_PLAYERS-1:0]     start,
    output logic [NUM_PLAYERS-1:0]     coin,
    output logic [8*NUM_DIP_BYTES-1:0] dip
);

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_WAIT_RELEASE
    } coinState_e;

    logic                            primed_q;
    logic                            oldToggle_q;
    logic [3:0][7:0]                 keyPlayer_q, keyPlayer_d;
    logic [3:0]                      keyStart_q, keyStart_d;
    logic [3:0]                      keyCoin_q, keyCoin_d;
    logic                            keyEvent;

    logic [NUM_PLAYERS-1:0][7:0]     rawPlayer, mergedPlayer;
    logic [NUM_PLAYERS-1:0]          rawStart, rawCoin;

    logic [NUM_PLAYERS-1:0][19:0]    afCount_q, afCount_d;
    logic [NUM_PLAYERS-1:0]          afPhase_q, afPhase_d;

    coinState_e                      coinState_q [NUM_PLAYERS];
    coinState_e                      coinState_d [NUM_PLAYERS];
    logic [23:0]                     coinCount_q [NUM_PLAYERS];
    logic [23:0]                     coinCount_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]          coinPrev_q;

    logic [NUM_PLAYERS-1:0][7:0]     players_q, players_d;
    logic [NUM_PLAYERS-1:0]          start_q, start_d;
    logic [NUM_PLAYERS-1:0]          coin_q, coin_d;
    logic [NUM_DIP_BYTES-1:0][7:0]   dip_q, dip_d;

    logic                            unusedBits;

    assign keyEvent = ps2_key[10] ^ oldToggle_q;

    // Bit order within a player byte: R, L, D, U, fire A..D.
    always_comb begin
        keyPlayer_d = keyPlayer_q;
        keyStart_d  = keyStart_q;
        keyCoin_d   = keyCoin_q;
        if (!primed_q && keyEvent) begin
            case (ps2_key[7:0])
                8'h74:        keyPlayer_d[0][0] = ps2_key[9];
                8'h6B:        keyPlayer_d[0][1] = ps2_key[9];
                8'h72:        keyPlayer_d[0][2] = ps2_key[9];
                8'h75:        keyPlayer_d[0][3] = ps2_key[9];
                8'h14:        keyPlayer_d[0][4] = ps2_key[9];
                8'h11:        keyPlayer_d[0][5] = ps2_key[9];
                8'h29:        keyPlayer_d[0][6] = ps2_key[9];
                8'h12:        keyPlayer_d[0][7] = ps2_key[9];
                8'h34:        keyPlayer_d[1][0] = ps2_key[9];
                8'h23:        keyPlayer_d[1][1] = ps2_key[9];
                8'h2B:        keyPlayer_d[1][2] = ps2_key[9];
                8'h2D:        keyPlayer_d[1][3] = ps2_key[9];
                8'h1C:        keyPlayer_d[1][4] = ps2_key[9];
                8'h1B:        keyPlayer_d[1][5] = ps2_key[9];
                8'h15:        keyPlayer_d[1][6] = ps2_key[9];
                8'h1D:        keyPlayer_d[1][7] = ps2_key[9];
                8'h05, 8'h16: keyStart_d[0]     = ps2_key[9];
                8'h06, 8'h1E: keyStart_d[1]     = ps2_key[9];
                8'h26:        keyStart_d[2]     = ps2_key[9];
                8'h25:        keyStart_d[3]     = ps2_key[9];
                8'h76, 8'h2E: keyCoin_d[0]      = ps2_key[9];
                8'h36:        keyCoin_d[1]      = ps2_key[9];
                8'h3D:        keyCoin_d[2]      = ps2_key[9];
                8'h3E:        keyCoin_d[3]      = ps2_key[9];
                default:      ;
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            rawPlayer[p] = keyPlayer_q[p] | joy[16*p +: 8];
            rawStart[p]  = keyStart_q[p] | joy[16*p+8];
            rawCoin[p]   = keyCoin_q[p] | joy[16*p+9];
        end
        mergedPlayer = rawPlayer;
        if (MERGE_PLAYERS == 1) begin
            for (int p = 1; p < NUM_PLAYERS; p++) begin
                mergedPlayer[0] = mergedPlayer[0] | rawPlayer[p];
            end
        end
    end

    // The phase bit selects the high or low half of the autofire wave.
    always_comb begin
        afCount_d = afCount_q;
        afPhase_d = afPhase_q;
        players_d = mergedPlayer;
        start_d   = rawStart;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (autofire_en[p] && mergedPlayer[p][4]) begin
                players_d[p][4] = ~afPhase_q[p];
                if (afCount_q[p] >= AUTOFIRE_DIV - 20'd1) begin
                    afCount_d[p] = '0;
                    afPhase_d[p] = ~afPhase_q[p];
                end else begin
                    afCount_d[p] = afCount_q[p] + 20'd1;
                end
            end else begin
                afCount_d[p] = '0;
                afPhase_d[p] = 1'b0;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            coinState_d[p] = coinState_q[p];
            coinCount_d[p] = coinCount_q[p];
            case (coinState_q[p])
                COIN_IDLE: begin
                    if (rawCoin[p] && !coinPrev_q[p]) begin
                        coinState_d[p] = COIN_PULSE;
                        coinCount_d[p] = COIN_CYCLES;
                    end
                end
                COIN_PULSE: begin
                    if (coinCount_q[p] <= 24'd1) begin
                        coinState_d[p] = rawCoin[p] ? COIN_WAIT_RELEASE : COIN_IDLE;
                        coinCount_d[p] = '0;
                    end else begin
                        coinCount_d[p] = coinCount_q[p] - 24'd1;
                    end
                end
                COIN_WAIT_RELEASE: begin
                    if (!rawCoin[p]) begin
                        coinState_d[p] = COIN_IDLE;
                    end
                end
                default: coinState_d[p] = COIN_IDLE;
            endcase
            coin_d[p] = (coinState_d[p] == COIN_PULSE);
        end
    end

    always_comb begin
        dip_d = dip_q;
        if (ioctl_wr && ioctl_index == 8'd254) begin
            for (int k = 0; k < NUM_DIP_BYTES; k++) begin
                if (ioctl_addr == 25'(k)) begin
                    dip_d[k] = ioctl_dout;
                end
            end
        end
    end

    // Priming swallows the first toggle sample so a held bit is not an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            primed_q    <= 1'b1;
            oldToggle_q <= 1'b0;
            keyPlayer_q <= '0;
            keyStart_q  <= '0;
            keyCoin_q   <= '0;
            afCount_q   <= '0;
            afPhase_q   <= '0;
            coinPrev_q  <= '0;
            players_q   <= '0;
            start_q     <= '0;
            coin_q      <= '0;
            dip_q       <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                coinState_q[p] <= COIN_IDLE;
                coinCount_q[p] <= '0;
            end
        end else begin
            primed_q    <= 1'b0;
            oldToggle_q <= ps2_key[10];
            keyPlayer_q <= keyPlayer_d;
            keyStart_q  <= keyStart_d;
            keyCoin_q   <= keyCoin_d;
            afCount_q   <= afCount_d;
            afPhase_q   <= afPhase_d;
            coinPrev_q  <= rawCoin;
            players_q   <= players_d;
            start_q     <= start_d;
            coin_q      <= coin_d;
            dip_q       <= dip_d;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                coinState_q[p] <= coinState_d[p];
                coinCount_q[p] <= coinCount_d[p];
            end
        end
    end

    assign players = players_q;
    assign start   = start_q;
    assign coin    = coin_q;
    assign dip     = dip_q;

    assign unusedBits = ^{ps2_key[8], joy, keyPlayer_q, keyStart_q, keyCoin_q};

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomized bench for arcade_input_mapper, checked cycle by cycle against a
// behavioural model of key map, merge, autofire, coin pulses and DIP capture.
module tb_arcade_input_mapper;

    localparam int DIV   = 3;
    localparam int COINN = 5;
    localparam int MERGE = 1;

    logic        clk_sys     = 1'b0;
    logic        reset_n     = 1'b0;
    logic [10:0] ps2_key     = 11'h400;
    logic [63:0] joy         = '0;
    logic [1:0]  autofire_en = '0;
    logic        ioctl_wr    = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic [24:0] ioctl_addr  = '0;
    logic [7:0]  ioctl_dout  = '0;
    logic [15:0] players;
    logic [1:0]  start;
    logic [1:0]  coin;
    logic [15:0] dip;

    int   testsRun  = 0;
    int   failCount = 0;
    logic ps2Toggle = 1'b1;

    logic [7:0] codeTable [24] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12,
                                   8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h15, 8'h1D,
                                   8'h05, 8'h16, 8'h06, 8'h1E, 8'h76, 8'h2E, 8'h36, 8'h3D};

    bit          keyFn [24];
    bit          mPrimed;
    bit          mOldToggle;
    int          heldCnt [2];
    int          coinLeft [2];
    bit          coinWait [2];
    bit          coinPrev [2];
    logic [7:0]  dipM [2];
    logic [15:0] expPlayers;
    logic [1:0]  expStart;
    logic [1:0]  expCoin;

    arcade_input_mapper #(
        .NUM_PLAYERS  (2),
        .NUM_DIP_BYTES(2),
        .MERGE_PLAYERS(MERGE),
        .COIN_CYCLES  (24'd5),
        .AUTOFIRE_DIV (20'd3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .joy        (joy),
        .autofire_en(autofire_en),
        .ioctl_wr   (ioctl_wr),
        .ioctl_index(ioctl_index),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .players    (players),
        .start      (start),
        .coin       (coin),
        .dip        (dip)
    );

    always #5 clk_sys = ~clk_sys;

    // Function index: 0-7 player 0 bits, 8-15 player 1 bits, 16-19 start, 20-23 coin.
    function automatic int keyFunction(input logic [7:0] code);
        case (code)
            8'h74: return 0;   8'h6B: return 1;   8'h72: return 2;   8'h75: return 3;
            8'h14: return 4;   8'h11: return 5;   8'h29: return 6;   8'h12: return 7;
            8'h34: return 8;   8'h23: return 9;   8'h2B: return 10;  8'h2D: return 11;
            8'h1C: return 12;  8'h1B: return 13;  8'h15: return 14;  8'h1D: return 15;
            8'h05, 8'h16: return 16;
            8'h06, 8'h1E: return 17;
            8'h26: return 18;  8'h25: return 19;
            8'h76, 8'h2E: return 20;
            8'h36: return 21;  8'h3D: return 22;  8'h3E: return 23;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 24; i++) keyFn[i] = 1'b0;
        mPrimed    = 1'b1;
        mOldToggle = 1'b0;
        for (int p = 0; p < 2; p++) begin
            heldCnt[p]  = 0;
            coinLeft[p] = 0;
            coinWait[p] = 1'b0;
            coinPrev[p] = 1'b0;
            dipM[p]     = 8'h00;
        end
        expPlayers = '0;
        expStart   = '0;
        expCoin    = '0;
    endtask

    task automatic modelStep();
        logic [7:0] raw [2];
        logic [7:0] merged [2];
        logic       rc;
        int         f;
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 8; b++)
                raw[p][b] = joy[16*p+b] | keyFn[8*p+b];
        merged[0] = (MERGE == 1) ? (raw[0] | raw[1]) : raw[0];
        merged[1] = raw[1];
        for (int p = 0; p < 2; p++) begin
            expPlayers[8*p +: 8] = merged[p];
            if (autofire_en[p] && merged[p][4]) begin
                expPlayers[8*p+4] = ((heldCnt[p] / DIV) % 2) == 0;
                heldCnt[p]++;
            end else begin
                heldCnt[p] = 0;
            end
            expStart[p] = keyFn[16+p] | joy[16*p+8];
            rc = keyFn[20+p] | joy[16*p+9];
            if (coinLeft[p] > 0) begin
                coinLeft[p]--;
                if (coinLeft[p] == 0 && rc) coinWait[p] = 1'b1;
            end else if (coinWait[p]) begin
                if (!rc) coinWait[p] = 1'b0;
            end else if (rc && !coinPrev[p]) begin
                coinLeft[p] = COINN;
            end
            coinPrev[p] = rc;
            expCoin[p]  = (coinLeft[p] > 0);
        end
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd2)
            dipM[ioctl_addr[0]] = ioctl_dout;
        if (mPrimed) begin
            mPrimed = 1'b0;
        end else if (ps2_key[10] != mOldToggle) begin
            f = keyFunction(ps2_key[7:0]);
            if (f >= 0) keyFn[f] = ps2_key[9];
        end
        mOldToggle = ps2_key[10];
    endtask

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        checkOutput("players", 32'(players), 32'(expPlayers));
        checkOutput("start", 32'(start), 32'(expStart));
        checkOutput("coin", 32'(coin), 32'(expCoin));
        checkOutput("dip", 32'(dip), 32'({dipM[1], dipM[0]}));
    endtask

    task automatic sendKey(input logic [7:0] code, input logic pressed, input logic ext);
        ps2Toggle = ~ps2Toggle;
        ps2_key   = {ps2Toggle, pressed, ext, code};
    endtask

    task automatic applyStimulus();
        int         idx;
        logic [7:0] code;
        for (int p = 0; p < 4; p++) begin
            if ($urandom_range(0, 5) == 0) begin
                idx = 16*p + (($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                          : int'($urandom_range(0, 9)));
                joy[idx] = ~joy[idx];
            end
        end
        if ($urandom_range(0, 15) == 0) autofire_en = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 4) == 0) code = 8'($urandom_range(0, 255));
            else                           code = codeTable[$urandom_range(0, 23)];
            sendKey(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        ioctl_wr    = ($urandom_range(0, 7) == 0);
        ioctl_index = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'd254;
        ioctl_addr  = 25'($urandom_range(0, 3));
        ioctl_dout  = 8'($urandom);
    endtask

    task automatic clearInputs();
        joy         = '0;
        autofire_en = '0;
        ioctl_wr    = 1'b0;
        for (int i = 0; i < 24; i++) begin
            sendKey(codeTable[i], 1'b0, 1'b0);
            tick();
        end
        sendKey(8'h26, 1'b0, 1'b0);
        tick();
        sendKey(8'h3E, 1'b0, 1'b0);
        repeat (10) tick();
    endtask

    task automatic writeDip(input logic [24:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = 8'd254;
        ioctl_addr  = addr;
        ioctl_dout  = data;
        tick();
    endtask

    initial begin
        int         coinHigh;
        logic [8:0] pattern;

        #2;
        checkOutput("resetPlayers", 32'(players), 32'd0);
        checkOutput("resetStart", 32'(start), 32'd0);
        checkOutput("resetCoin", 32'(coin), 32'd0);
        checkOutput("resetDip", 32'(dip), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;

        // Toggle bit held high across reset release must not count as an event.
        repeat (4) begin
            tick();
            checkOutput("primeIdle", 32'(players), 32'd0);
        end
        sendKey(8'h75, 1'b1, 1'b0);
        tick();
        checkOutput("keyLatency1", 32'(players[3]), 32'd0);
        tick();
        checkOutput("keyLatency2", 32'(players[3]), 32'd1);
        sendKey(8'h75, 1'b0, 1'b0);
        repeat (2) tick();

        joy[16] = 1'b1;
        tick();
        checkOutput("mergeP0", 32'(players[0]), 32'd1);
        checkOutput("mergeP1", 32'(players[8]), 32'd1);
        joy[16] = 1'b0;
        tick();

        repeat (3000) begin
            applyStimulus();
            tick();
        end
        clearInputs();

        coinHigh = 0;
        joy[9] = 1'b1;
        repeat (20) begin
            tick();
            coinHigh += int'(coin[0]);
        end
        checkOutput("coinHeld", 32'(coinHigh), 32'd5);
        joy[9] = 1'b0;
        repeat (3) tick();
        coinHigh = 0;
        joy[9] = 1'b1;
        repeat (10) begin
            tick();
            coinHigh += int'(coin[0]);
        end
        checkOutput("coinRepress", 32'(coinHigh), 32'd5);
        joy[9] = 1'b0;
        repeat (3) tick();

        autofire_en = 2'b01;
        joy[4] = 1'b1;
        pattern = '0;
        repeat (9) begin
            tick();
            pattern = {pattern[7:0], players[4]};
        end
        checkOutput("autofirePattern", 32'(pattern), 32'b111000111);
        joy[4] = 1'b0;
        tick();
        checkOutput("autofireRelease", 32'(players[4]), 32'd0);
        autofire_en = 2'b00;

        writeDip(25'd0, 8'hA5);
        writeDip(25'd1, 8'h3C);
        writeDip(25'd2, 8'hFF);
        ioctl_wr = 1'b0;
        tick();
        checkOutput("dipBytes", 32'(dip), 32'h3CA5);

        joy[9] = 1'b1;
        sendKey(8'h14, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("coinBeforeReset", 32'(coin[0]), 32'd1);
        checkOutput("keyBeforeReset", 32'(players[4]), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("asyncPlayers", 32'(players), 32'd0);
        checkOutput("asyncStart", 32'(start), 32'd0);
        checkOutput("asyncCoin", 32'(coin), 32'd0);
        checkOutput("asyncDip", 32'(dip), 32'd0);
        tick();
        reset_n = 1'b1;
        coinHigh = 0;
        repeat (12) begin
            tick();
            coinHigh += int'(coin[0]);
        end
        checkOutput("coinThroughReset", 32'(coinHigh), 32'd5);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
